// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the register-file write data from the execute-stage results,
// resolves load data returning from the memory bus (alignment and sign extension), and owns
// the load-wait state machine.
//
// Ports:
//   clk, sync_rst_n   clock and synchronous active-low reset
//   clk_en            pipeline advance enable from the hazard unit
//   ctr_in            writeback select (000 none, 001 ALU, 010 load, 011 link, 100 LUI)
//   inst_u_imm_in     U-type immediate upper bits
//   inst_fn3_in       load width/sign code
//   rd_addr_in        destination register
//   alu_in            ALU result; [1:0] is the load byte offset
//   inc_pc_in         word address of PC+4
//   mem_data_in       memory read data, big-endian lanes (offset 0 in [31:24])
//   mem_ready         read data valid this cycle
//   rd_we/rd_waddr/rd_wdata  registered register-file write port
//   stall             hold upstream stages while a load is outstanding
//   load_fault        one-cycle pulse when a load times out
module writeback_stage #(
  parameter int unsigned LOAD_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 10
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        clk_en,
  input  logic [2:0]  ctr_in,
  input  logic [19:0] inst_u_imm_in,
  input  logic [2:0]  inst_fn3_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] alu_in,
  input  logic [29:0] inc_pc_in,
  input  logic [31:0] mem_data_in,
  input  logic        mem_ready,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        stall,
  output logic        load_fault
);

  localparam logic [2:0] CtrAlu  = 3'b001;
  localparam logic [2:0] CtrLoad = 3'b010;
  localparam logic [2:0] CtrLink = 3'b011;
  localparam logic [2:0] CtrLui  = 3'b100;

  typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       ld_fn3_q;
  logic [4:0]       ld_rd_q;
  logic [1:0]       ld_off_q;
  logic             rd_we_q;
  logic [4:0]       rd_waddr_q;
  logic [31:0]      rd_wdata_q;
  logic             load_fault_q;

  // Lane k of the bus sits at [31-8k -: 8]; halves and words are assembled little-endian.
  function automatic logic [31:0] load_align(input logic [31:0] data, input logic [2:0] fn3,
                                             input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    case (off)
      2'd0:    b = data[31:24];
      2'd1:    b = data[23:16];
      2'd2:    b = data[15:8];
      default: b = data[7:0];
    endcase
    h = off[1] ? {data[7:0], data[15:8]} : {data[23:16], data[31:24]};
    w = {data[7:0], data[15:8], data[23:16], data[31:24]};
    case (fn3)
      3'd0:    load_align = {{24{b[7]}}, b};
      3'd4:    load_align = {24'h0, b};
      3'd1:    load_align = {{16{h[15]}}, h};
      3'd5:    load_align = {16'h0, h};
      3'd2:    load_align = w;
      default: load_align = 32'h0;
    endcase
  endfunction

  logic        idle_wr;
  logic [31:0] idle_data;
  logic [31:0] wait_data;
  logic        idle_load_miss;

  always_comb begin
    idle_wr   = 1'b0;
    idle_data = 32'h0;
    case (ctr_in)
      CtrAlu: begin
        idle_wr   = 1'b1;
        idle_data = alu_in;
      end
      CtrLoad: begin
        idle_wr   = 1'b1;
        idle_data = load_align(mem_data_in, inst_fn3_in, alu_in[1:0]);
      end
      CtrLink: begin
        idle_wr   = 1'b1;
        idle_data = {inc_pc_in, 2'b00};
      end
      CtrLui: begin
        idle_wr   = 1'b1;
        idle_data = {inst_u_imm_in, 12'h000};
      end
      default: ;
    endcase
    wait_data      = load_align(mem_data_in, ld_fn3_q, ld_off_q);
    idle_load_miss = (ctr_in == CtrLoad) && clk_en && !mem_ready;
  end

  // Stall covers the first wait cycle combinationally so execute freezes on the accepting edge.
  assign stall = sync_rst_n &&
                 ((state_q == StLoadWait) || ((state_q == StIdle) && idle_load_miss));

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ld_fn3_q     <= 3'h0;
      ld_rd_q      <= 5'h0;
      ld_off_q     <= 2'h0;
      rd_we_q      <= 1'b0;
      rd_waddr_q   <= 5'h0;
      rd_wdata_q   <= 32'h0;
      load_fault_q <= 1'b0;
    end else begin
      rd_we_q      <= 1'b0;
      load_fault_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clk_en) begin
            if (idle_load_miss) begin
              state_q  <= StLoadWait;
              cnt_q    <= CNT_W'(1);
              ld_fn3_q <= inst_fn3_in;
              ld_rd_q  <= rd_addr_in;
              ld_off_q <= alu_in[1:0];
            end else if (idle_wr && (rd_addr_in != 5'd0)) begin
              rd_we_q    <= 1'b1;
              rd_waddr_q <= rd_addr_in;
              rd_wdata_q <= idle_data;
            end
          end
        end
        StLoadWait: begin
          if (mem_ready) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            if (ld_rd_q != 5'd0) begin
              rd_we_q    <= 1'b1;
              rd_waddr_q <= ld_rd_q;
              rd_wdata_q <= wait_data;
            end
          end else if (cnt_q == CNT_W'(LOAD_TIMEOUT)) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            load_fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_we      = rd_we_q;
  assign rd_waddr   = rd_waddr_q;
  assign rd_wdata   = rd_wdata_q;
  assign load_fault = load_fault_q;

endmodule
